alu_resp_unit: RTL and testbench

Registered, handshaked responder for the 4-operation ALU (NAND, XOR, ADD, SUB with signed-overflow error). It accepts operation requests from an initiator over a valid/ready channel, computes the result, and queues results with their error flags in a 2-entry in-order response buffer drained over a second valid/ready channel. It also keeps a saturating count of overflow errors. It sits between the decode/issue logic (or a stimulus driver) and the writeback/checker side of the datapath.

---
 rtl/alu_resp_unit.sv | 103 ++++++++++
 tb/tb_alu_resp_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_resp_unit.sv
// Handshaked 4-op ALU responder with a 2-entry in-order response buffer and a
// saturating overflow counter. Request accept and response pop share one clock.
module alu_resp_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_error,
  output logic [7:0]       err_count
);

  function automatic logic [WIDTH:0] alu_eval(input logic [1:0] op,
                                              input logic signed [WIDTH-1:0] a,
                                              input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] r;
    logic                    e;
    r = '0;
    e = 1'b0;
    case (op)
      2'b00: r = ~(a & b);
      2'b01: r = a ^ b;
      2'b10: begin
        r = a + b;
        e = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        r = a - b;
        e = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
    return {e, r};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [WIDTH-1:0] res_mem [2];
  logic             err_mem [2];
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [WIDTH:0]   eval;
  logic             push, pop;

  assign eval      = alu_eval(in_opcode, in_a, in_b);
  assign in_ready  = (count_q < 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = out_valid ? res_mem[rd_ptr_q] : '0;
  assign out_error  = out_valid ? err_mem[rd_ptr_q] : 1'b0;
  assign err_count  = err_cnt_q;

  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_cnt_d = err_cnt_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push && eval[WIDTH]) err_cnt_d = sat_inc8(err_cnt_q);
  end

  // Control state: cleared asynchronously so buffered entries vanish at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr_q] <= eval[WIDTH-1:0];
      err_mem[wr_ptr_q] <= eval[WIDTH];
    end
  end

endmodule

// File: tb/tb_alu_resp_unit.sv
// Directed bench for alu_resp_unit (WIDTH=4): opcodes, overflow flags,
// backpressure ordering, push/pop streaming, async reset and counter saturation.
module tb_alu_resp_unit;
  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_opcode;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_error;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OP_NAND = 2'b00, OP_XOR = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11;

  alu_resp_unit #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_error(out_error), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    in_valid  = v;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
  endtask

  // One request into an empty buffer with out_ready=1; checks the response a cycle later.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] er, input logic ee);
    @(negedge clk);
    drive(1'b1, op, a, b);
    @(negedge clk);
    drive(1'b0, OP_NAND, 4'h0, 4'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'h1);
    chk({tag, "_result"}, 32'(out_result), 32'(er));
    chk({tag, "_error"}, 32'(out_error), 32'(ee));
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, OP_NAND, 4'h0, 4'h0);

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_result", 32'(out_result), 32'h0);
    chk("rst_out_error", 32'(out_error), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Logic ops
    do_op("nand_5_3", OP_NAND, 4'h5, 4'h3, 4'hE, 1'b0);
    do_op("xor_a_6", OP_XOR, 4'hA, 4'h6, 4'hC, 1'b0);
    chk("err_count_logic", 32'(err_count), 32'h0);

    // ADD
    do_op("add_7_1", OP_ADD, 4'h7, 4'h1, 4'h8, 1'b1);
    do_op("add_8_f", OP_ADD, 4'h8, 4'hF, 4'h7, 1'b1);
    do_op("add_3_2", OP_ADD, 4'h3, 4'h2, 4'h5, 1'b0);
    chk("err_count_add", 32'(err_count), 32'h2);

    // SUB
    do_op("sub_8_1", OP_SUB, 4'h8, 4'h1, 4'h7, 1'b1);
    do_op("sub_3_5", OP_SUB, 4'h3, 4'h5, 4'hE, 1'b0);
    do_op("sub_7_f", OP_SUB, 4'h7, 4'hF, 4'h8, 1'b1);
    chk("err_count_sub", 32'(err_count), 32'h4);

    // Backpressure and ordering
    @(negedge clk);
    chk("bp_empty_valid", 32'(out_valid), 32'h0);
    chk("bp_empty_result", 32'(out_result), 32'h0);
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 4'h1, 4'h1);
    @(negedge clk);
    chk("bp_ready_after_1", 32'(in_ready), 32'h1);
    drive(1'b1, OP_XOR, 4'hF, 4'h1);
    @(negedge clk);
    chk("bp_ready_full", 32'(in_ready), 32'h0);
    chk("bp_head0", 32'(out_result), 32'h2);
    drive(1'b1, OP_NAND, 4'hF, 4'hF);
    @(negedge clk);
    chk("bp_ready_held", 32'(in_ready), 32'h0);
    chk("bp_head_stable", 32'(out_result), 32'h2);
    chk("bp_head_err_stable", 32'(out_error), 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head1", 32'(out_result), 32'hE);
    chk("bp_ready_reopen", 32'(in_ready), 32'h1);
    @(negedge clk);
    drive(1'b0, OP_NAND, 4'h0, 4'h0);
    chk("bp_head2_valid", 32'(out_valid), 32'h1);
    chk("bp_head2", 32'(out_result), 32'h0);
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'h0);
    chk("bp_err_count", 32'(err_count), 32'h4);

    // Streaming push+pop at occupancy 1
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("stream_valid_%0d", i - 1), 32'(out_valid), 32'h1);
        chk($sformatf("stream_res_%0d", i - 1), 32'(out_result), 32'((i - 1) ^ 9));
        chk($sformatf("stream_ready_%0d", i - 1), 32'(in_ready), 32'h1);
      end
      if (i < 8) drive(1'b1, OP_XOR, 4'(i), 4'h9);
      else       drive(1'b0, OP_NAND, 4'h0, 4'h0);
    end
    @(negedge clk);
    chk("stream_drained", 32'(out_valid), 32'h0);

    // Async reset with two entries buffered and err_count=5
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 4'h7, 4'h1);
    @(negedge clk);
    drive(1'b1, OP_XOR, 4'h0, 4'h0);
    @(negedge clk);
    drive(1'b1, OP_ADD, 4'h7, 4'h1);
    chk("pre_rst_full", 32'(in_ready), 32'h0);
    chk("pre_rst_err_count", 32'(err_count), 32'h5);
    chk("pre_rst_head", 32'(out_result), 32'h8);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_result", 32'(out_result), 32'h0);
    chk("mid_rst_err_count", 32'(err_count), 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, OP_NAND, 4'h0, 4'h0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("after_rst_in_ready", 32'(in_ready), 32'h1);
    chk("after_rst_valid", 32'(out_valid), 32'h0);
    chk("after_rst_err_count", 32'(err_count), 32'h0);

    // Saturation: 260 overflowing ADDs
    drive(1'b1, OP_ADD, 4'h7, 4'h1);
    repeat (254) @(negedge clk);
    chk("sat_254", 32'(err_count), 32'd254);
    repeat (6) @(negedge clk);
    drive(1'b0, OP_NAND, 4'h0, 4'h0);
    chk("sat_255", 32'(err_count), 32'd255);
    chk("sat_head_err", 32'(out_error), 32'h1);
    @(negedge clk);
    chk("sat_hold", 32'(err_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
